fbsb_frame_tx: RTL and testbench
================================

FBSB_FRAME_TX -- requirements
Module: fbsb_frame_tx

Interface
REQ-001 Parameter BIT_CYCLES, 50, pclk cycles per line bit (>=2).
REQ-002 Parameter SYNC_BITS, 5, bit periods in each of the sync-high and sync-low phases (>=1).
REQ-003 Parameter GAP_BITS, 2, low bit periods after each frame (>=1).
REQ-004 Parameter MAX_FRAME_BYTES, 24, byte limit per frame (1..255).
REQ-005 pclk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 s_valid  in  1  byte offered.
REQ-008 s_data  in  8  byte to encode.
REQ-009 s_last  in  1  offered byte ends its frame.
REQ-010 s_ready  out  1  one-byte holding register empty.
REQ-011 tx  out  1  registered line output.
REQ-012 busy  out  1  state != IDLE.
REQ-013 frame_done  out  1  one-cycle pulse on the GAP->IDLE transition.
REQ-014 underrun  out  1  one-cycle pulse when a frame ends for lack of data.
REQ-015 trunc  out  1  one-cycle pulse when a frame ends at MAX_FRAME_BYTES without s_last.

Function
REQ-016 Handshake: a byte (with its s_last) is accepted into the holding register on any cycle where s_valid && s_ready; s_ready = holding empty; accepting is legal in every state.
REQ-017 Encoding: each nibble maps through the 4B6B table (0:001110 1:001101 2:010011 3:010110 4:010101 5:100011 6:100110 7:100101 8:011001 9:011010 A:011100 B:110001 C:110010 D:101001 E:101010 F:101100, written bit5..bit0); symbol = {code(hi), code(lo)}, 12 bits, sent bit0 first (low nibble first).
REQ-018 States: IDLE, SYNC_HI, SYNC_LO, DATA, GAP; tx = 0 in IDLE, SYNC_LO, GAP; tx = 1 in SYNC_HI; tx = current symbol bit in DATA.
REQ-019 IDLE -> SYNC_HI when holding is full; tx first reads 1 two cycles after the accept cycle.
REQ-020 Every line bit lasts exactly BIT_CYCLES cycles; SYNC_HI and SYNC_LO last SYNC_BITS*BIT_CYCLES each; GAP lasts GAP_BITS*BIT_CYCLES.
REQ-021 On the last cycle of SYNC_LO, or of bit 11 of a symbol, a full holding register is moved into the symbol shift register; the holding register empties in that cycle, and s_ready rises the following cycle.
REQ-022 Consecutive symbols in a frame are contiguous: no idle bit periods between them.
REQ-023 The frame ends after bit 11 with DATA -> GAP when the sent byte had s_last=1 (no pulse), byte count == MAX_FRAME_BYTES (trunc pulse), or holding is empty (underrun pulse). Priority is last > trunc > underrun; at most one pulse per frame.
REQ-024 After truncation, a byte still in the holding register starts the next frame after GAP.
REQ-025 Byte counter: 8 bits, cleared in IDLE, incremented per symbol loaded; the bit counter width is clog2(max(SYNC_BITS,GAP_BITS)*BIT_CYCLES).
REQ-026 GAP -> IDLE with a frame_done pulse; if holding is full, IDLE exits on the next cycle.

Reset
REQ-027 While reset is high, at the next edge: state = IDLE, tx = 0, busy = 0, s_ready = 1, frame_done/underrun/trunc = 0, holding and counters cleared; reset in mid-frame aborts the frame with no pulses.

Structure
REQ-028 Package fbsb_pkg holds the state enumeration, the 4B6B table constant and default parameter values.
REQ-029 One sub-module, fbsb_nibble_map: a combinational 4-bit to 6-bit table, instantiated twice.

Verification (BIT_CYCLES=4, SYNC_BITS=2, GAP_BITS=1, MAX_FRAME_BYTES=2)
REQ-030 Single 0x00 with s_last -> tx: 8 cycles 1, 8 cycles 0, then 0,1,1,1,0,0,0,1,1,1,0,0 at 4 cycles each, 4 cycles 0, then a frame_done pulse.
REQ-031 0xA5 then 0x3C with s_last, s_valid held -> symbols contiguous: 1,1,0,0,0,1,0,0,1,1,1,0 then 0,1,0,0,1,1,0,1,1,0,1,0; s_ready low except one cycle after each load.
REQ-032 Single byte without s_last, no further data -> one symbol, GAP, underrun and frame_done pulses once each.
REQ-033 Three bytes, none with s_last -> frame of 2 symbols, trunc pulse, GAP, then a new frame with sync carrying byte 3 (which then underruns).
REQ-034 reset raised during DATA bit 5 -> next cycle tx=0, busy=0, s_ready=1, no pulses; a new byte then starts a clean sync.

Source files
------------

// File: rtl/fbsb_pkg.sv
// Shared definitions for the FBSB frame transmitter:
// FSM states, 4B6B code table and default parameter values.
package fbsb_pkg;

    localparam int DEF_BIT_CYCLES      = 50;
    localparam int DEF_SYNC_BITS       = 5;
    localparam int DEF_GAP_BITS        = 2;
    localparam int DEF_MAX_FRAME_BYTES = 24;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_HI,
        SYNC_LO,
        DATA,
        GAP
    } fbsb_state_e;

    // Entries are listed from nibble F down to nibble 0.
    localparam logic [15:0][5:0] CODE_4B6B = {
        6'b101100, 6'b101010, 6'b101001, 6'b110010,
        6'b110001, 6'b011100, 6'b011010, 6'b011001,
        6'b100101, 6'b100110, 6'b100011, 6'b010101,
        6'b010110, 6'b010011, 6'b001101, 6'b001110
    };

endpackage

// File: rtl/fbsb_nibble_map.sv
// Combinational 4B6B lookup: one data nibble to one
// six-bit line code.
module fbsb_nibble_map
    import fbsb_pkg::*;
(
    input  logic [3:0] nib,
    output logic [5:0] code
);

    assign code = CODE_4B6B[nib];

endmodule

// File: rtl/fbsb_frame_tx.sv
// FBSB frame transmitter: one-byte holding register, sync
// preamble, 4B6B-coded symbols and an inter-frame gap.
module fbsb_frame_tx
    import fbsb_pkg::*;
#(
    parameter int BIT_CYCLES      = DEF_BIT_CYCLES,
    parameter int SYNC_BITS       = DEF_SYNC_BITS,
    parameter int GAP_BITS        = DEF_GAP_BITS,
    parameter int MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    output logic       trunc
);

    localparam int SYNC_LEN = SYNC_BITS * BIT_CYCLES;
    localparam int GAP_LEN  = GAP_BITS * BIT_CYCLES;
    localparam int PH_BITS  = (SYNC_BITS > GAP_BITS) ? SYNC_BITS : GAP_BITS;
    localparam int CW       = $clog2(PH_BITS * BIT_CYCLES);

    localparam logic [CW-1:0] SYNC_END = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYCLES - 1);
    localparam logic [7:0]    MAX_B    = 8'(MAX_FRAME_BYTES);

    fbsb_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    nbytes_q, nbytes_d;
    logic [11:0]   sr_q, sr_d;
    logic          sym_last_q, sym_last_d;

    logic [7:0]    hold_data_q;
    logic          hold_last_q;
    logic          hold_full_q;

    logic          load;
    logic          tx_d;
    logic          done_d;
    logic          under_d;
    logic          trunc_d;
    logic [5:0]    code_lo;
    logic [5:0]    code_hi;

    fbsb_nibble_map u_map_lo (
        .nib  (hold_data_q[3:0]),
        .code (code_lo)
    );

    fbsb_nibble_map u_map_hi (
        .nib  (hold_data_q[7:4]),
        .code (code_hi)
    );

    assign s_ready = !hold_full_q;
    assign busy    = (state_q != IDLE);

    always_ff @(posedge pclk) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
        end else begin
            if (load) begin
                hold_full_q <= 1'b0;
            end
            if (s_valid && s_ready) begin
                hold_full_q <= 1'b1;
                hold_data_q <= s_data;
                hold_last_q <= s_last;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        nbytes_d   = nbytes_q;
        sr_d       = sr_q;
        sym_last_d = sym_last_q;
        load       = 1'b0;
        done_d     = 1'b0;
        under_d    = 1'b0;
        trunc_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                nbytes_d = '0;
                if (hold_full_q) begin
                    state_d = SYNC_HI;
                end
            end
            SYNC_HI: begin
                if (cnt_q == SYNC_END) begin
                    cnt_d   = '0;
                    state_d = SYNC_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SYNC_LO: begin
                if (cnt_q == SYNC_END) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (idx_q == 4'd11) begin
                        idx_d = '0;
                        // frame end priority: s_last, then limit, then starvation
                        if (sym_last_q) begin
                            state_d = GAP;
                        end else if (nbytes_q == MAX_B) begin
                            state_d = GAP;
                            trunc_d = 1'b1;
                        end else if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = GAP;
                            under_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                        sr_d  = {1'b0, sr_q[11:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            sr_d       = {code_hi, code_lo};
            sym_last_d = hold_last_q;
            nbytes_d   = nbytes_q + 8'd1;
        end

        // tx is registered alongside the state, so derive it from next values
        tx_d = (state_d == SYNC_HI) || ((state_d == DATA) && sr_d[0]);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            nbytes_q   <= '0;
            sr_q       <= '0;
            sym_last_q <= 1'b0;
            tx         <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            trunc      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            nbytes_q   <= nbytes_d;
            sr_q       <= sr_d;
            sym_last_q <= sym_last_d;
            tx         <= tx_d;
            frame_done <= done_d;
            underrun   <= under_d;
            trunc      <= trunc_d;
        end
    end

endmodule

// File: tb/tb_fbsb_frame_tx.sv
// Self-checking bench for fbsb_frame_tx: encoding table,
// directed frame corners and random streams vs. a line model.
module tb_fbsb_frame_tx;

    localparam int BC       = 4;
    localparam int SB       = 2;
    localparam int GB       = 1;
    localparam int MB       = 2;
    localparam int SYNC_CYC = SB * BC;
    localparam int GAP_CYC  = GB * BC;
    localparam int MAXC     = 2048;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic       underrun;
    logic       trunc;

    int total = 0;
    int bad   = 0;

    logic [7:0] qd[$];
    logic       ql[$];
    logic [4:0] exp_q[$];
    logic       rdy_tr[MAXC];
    logic [4:0] obs_tr[MAXC];

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [11:0] sym;
        logic        un;
    } vec_t;

    vec_t tbl[6];

    fbsb_frame_tx #(
        .BIT_CYCLES      (BC),
        .SYNC_BITS       (SB),
        .GAP_BITS        (GB),
        .MAX_FRAME_BYTES (MB)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun),
        .trunc      (trunc)
    );

    always #5 pclk = ~pclk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] code6(input logic [3:0] n);
        case (n)
            4'h0: return 6'b001110;
            4'h1: return 6'b001101;
            4'h2: return 6'b010011;
            4'h3: return 6'b010110;
            4'h4: return 6'b010101;
            4'h5: return 6'b100011;
            4'h6: return 6'b100110;
            4'h7: return 6'b100101;
            4'h8: return 6'b011001;
            4'h9: return 6'b011010;
            4'hA: return 6'b011100;
            4'hB: return 6'b110001;
            4'hC: return 6'b110010;
            4'hD: return 6'b101001;
            4'hE: return 6'b101010;
            default: return 6'b101100;
        endcase
    endfunction

    function automatic logic [4:0] outs();
        return {tx, busy, frame_done, underrun, trunc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Expected per-cycle {tx,busy,done,under,trunc} for a byte stream
    // that is always offered as soon as the transmitter can take it.
    task automatic build_exp();
        int          i;
        int          k;
        bit          ends;
        logic        un;
        logic        tr;
        logic [7:0]  b8;
        logic [11:0] s;
        i = 0;
        exp_q.delete();
        repeat (2) exp_q.push_back(5'b00000);
        while (i < qd.size()) begin
            repeat (SYNC_CYC) exp_q.push_back(5'b11000);
            repeat (SYNC_CYC) exp_q.push_back(5'b01000);
            k = 0;
            un = 1'b0;
            tr = 1'b0;
            ends = 1'b0;
            while (!ends) begin
                b8 = qd[i];
                s = {code6(b8[7:4]), code6(b8[3:0])};
                for (int b = 0; b < 12; b++)
                    repeat (BC) exp_q.push_back({s[b], 4'b1000});
                k++;
                if (ql[i]) begin
                    ends = 1'b1;
                end else if (k == MB) begin
                    tr = 1'b1;
                    ends = 1'b1;
                end else if (i + 1 == qd.size()) begin
                    un = 1'b1;
                    ends = 1'b1;
                end
                i++;
            end
            exp_q.push_back({3'b010, un, tr});
            repeat (GAP_CYC - 1) exp_q.push_back(5'b01000);
            exp_q.push_back(5'b00100);
        end
        repeat (6) exp_q.push_back(5'b00000);
    endtask

    task automatic run_stream(input string nm);
        int   idx;
        logic acc;
        idx = 0;
        build_exp();
        @(posedge pclk); #1;
        s_valid = 1'b1;
        s_data  = qd[0];
        s_last  = ql[0];
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge pclk);
            if (c < MAXC) rdy_tr[c] = s_ready;
            total++;
            if (outs() !== exp_q[c]) begin
                bad++;
                $display("FAIL %s cyc %0d: {tx,busy,done,under,trunc} got %b expected %b",
                         nm, c, outs(), exp_q[c]);
            end
            acc = s_valid && s_ready;
            @(posedge pclk); #1;
            if (acc) begin
                idx++;
                if (idx < qd.size()) begin
                    s_data = qd[idx];
                    s_last = ql[idx];
                end else begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                end
            end
        end
    endtask

    task automatic capture(input logic [7:0] d, input logic l, input int n);
        @(posedge pclk); #1;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int c = 0; c < n; c++) begin
            @(negedge pclk);
            obs_tr[c] = outs();
            @(posedge pclk); #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    initial begin
        int          first;
        int          n_un;
        int          n_fd;
        int          n_tr;
        int          n_busy;
        int          n_rdy;
        int          quiet;
        logic [11:0] got;

        tbl[0] = '{8'h00, 1'b1, 12'b011100011100, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 12'b110001001110, 1'b0};
        tbl[2] = '{8'h3C, 1'b1, 12'b010011011010, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 12'b001101001101, 1'b1};
        tbl[4] = '{8'h5A, 1'b1, 12'b001110110001, 1'b0};
        tbl[5] = '{8'h12, 1'b0, 12'b110010101100, 1'b1};

        reset = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset_tx", tx, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", s_ready, 1);
        chk("reset_pulses", {frame_done, underrun, trunc}, 0);
        @(posedge pclk); #1;
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            capture(tbl[v].d, tbl[v].l, 80);
            first = -1;
            n_un = 0;
            n_fd = 0;
            n_tr = 0;
            n_busy = 0;
            for (int c = 0; c < 80; c++) begin
                if (first < 0 && obs_tr[c][4]) first = c;
                n_busy += int'(obs_tr[c][3]);
                n_fd   += int'(obs_tr[c][2]);
                n_un   += int'(obs_tr[c][1]);
                n_tr   += int'(obs_tr[c][0]);
            end
            for (int b = 0; b < 12; b++)
                got[11 - b] = obs_tr[2 + 2 * SYNC_CYC + b * BC + 1][4];
            chk($sformatf("tbl%0d_first_hi", v), first, 2);
            chk($sformatf("tbl%0d_symbol", v), got, tbl[v].sym);
            chk($sformatf("tbl%0d_busy_len", v), n_busy,
                2 * SYNC_CYC + 12 * BC + GAP_CYC);
            chk($sformatf("tbl%0d_done", v), n_fd, 1);
            chk($sformatf("tbl%0d_under", v), n_un, int'(tbl[v].un));
            chk($sformatf("tbl%0d_trunc", v), n_tr, 0);
        end

        qd = '{8'h00};
        ql = '{1'b1};
        run_stream("single_last");

        qd = '{8'hA5, 8'h3C};
        ql = '{1'b0, 1'b1};
        run_stream("two_contig");
        n_rdy = 0;
        for (int c = 1; c <= 65; c++) n_rdy += int'(rdy_tr[c]);
        chk("ready_after_load0", rdy_tr[18], 1);
        chk("ready_high_count", n_rdy, 1);
        chk("ready_after_load1", rdy_tr[66], 1);

        qd = '{8'h5A};
        ql = '{1'b0};
        run_stream("underrun");

        qd = '{8'h11, 8'h22, 8'h33};
        ql = '{1'b0, 1'b0, 1'b0};
        run_stream("truncate");

        @(posedge pclk); #1;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        s_last  = 1'b0;
        @(posedge pclk); #1;
        s_valid = 1'b0;
        repeat (38) @(posedge pclk);
        #1;
        reset = 1'b1;
        @(negedge pclk);
        chk("mid_busy", busy, 1);
        chk("mid_bit5_tx", tx, 0);
        @(posedge pclk); #1;
        reset = 1'b0;
        @(negedge pclk);
        chk("abort_tx", tx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", s_ready, 1);
        chk("abort_pulses", {frame_done, underrun, trunc}, 0);
        quiet = 0;
        repeat (60) begin
            @(negedge pclk);
            if (outs() != 5'b00000) quiet++;
        end
        chk("abort_quiet", quiet, 0);

        qd = '{8'h12};
        ql = '{1'b1};
        run_stream("after_reset");

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 6);
            qd.delete();
            ql.delete();
            for (int j = 0; j < n; j++) begin
                qd.push_back(8'($urandom_range(0, 255)));
                ql.push_back($urandom_range(0, 2) == 0);
            end
            run_stream($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
